aibnd_dly_code_ctl: RTL and testbench



---
 rtl/aibnd_dly_code_ctl.sv | 94 +++++++++
 tb/tb_aibnd_dly_code_ctl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aibnd_dly_code_ctl.sv
// Sequencer for the NAND delay-line stage enables: walks bk one thermometer step per move toward a requested stage count.
// Latency: first bk step at T+3 after acceptance, one step per SETTLE+1 cycles, code_valid at T+3+d*(SETTLE+1).
// Backpressure: req_rdy is low while a transition is in progress or in reset; requests are not queued.
module aibnd_dly_code_ctl #(
    parameter int NSTG   = 6,
    parameter int CW     = 3,
    parameter int SETTLE = 4
) (
    input  logic            ck,
    input  logic            rst,
    input  logic            req_vld,
    input  logic [CW-1:0]   req_code,
    output logic            req_rdy,
    output logic [NSTG-1:0] bk,
    output logic            code_valid,
    output logic [CW-1:0]   cur_code,
    output logic            busy,
    output logic            err
);
    localparam int              CNTW     = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CNTW-1:0] CNT_LOAD = (SETTLE > 0) ? CNTW'(SETTLE - 1) : '0;
    localparam logic [CW-1:0]   MAX_CODE = CW'(NSTG);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;
    localparam logic [1:0] ST_SETL = 2'd3;

    // With no settle time the walker steps on back-to-back cycles.
    localparam logic [1:0] ST_AFTER_MOVE = (SETTLE > 0) ? ST_SETL : ST_STEP;

    logic [1:0]      state;
    logic [CW-1:0]   target;
    logic [CNTW-1:0] cnt;
    logic [CW-1:0]   req_clamp;

    assign req_clamp = (req_code > MAX_CODE) ? MAX_CODE : req_code;
    assign busy      = (state != ST_IDLE);
    assign req_rdy   = (state == ST_IDLE) && !rst;

    always_ff @(posedge ck) begin
        if (rst) begin
            state      <= ST_IDLE;
            target     <= '0;
            cnt        <= '0;
            bk         <= '0;
            cur_code   <= '0;
            code_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_vld) begin
                        target <= req_clamp;
                        if (req_code > MAX_CODE) begin
                            err <= 1'b1;
                        end
                        // Re-requesting the code already on the line must not glitch code_valid.
                        if (!((req_clamp == cur_code) && code_valid)) begin
                            state      <= ST_HOLD;
                            code_valid <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    state <= ST_STEP;
                end
                ST_STEP: begin
                    if (cur_code < target) begin
                        bk       <= (bk << 1) | NSTG'(1);
                        cur_code <= cur_code + CW'(1);
                        cnt      <= CNT_LOAD;
                        state    <= ST_AFTER_MOVE;
                    end else if (cur_code > target) begin
                        bk       <= bk >> 1;
                        cur_code <= cur_code - CW'(1);
                        cnt      <= CNT_LOAD;
                        state    <= ST_AFTER_MOVE;
                    end else begin
                        code_valid <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        state <= ST_STEP;
                    end else begin
                        cnt <= cnt - CNTW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aibnd_dly_code_ctl.sv
// Self-checking bench for aibnd_dly_code_ctl: table-driven sequences, reset corner cases and randomized requests
// against a schedule-based reference model; a second instance covers the zero-settle build.
module tb_aibnd_dly_code_ctl;
    localparam int NSTG = 6;
    localparam int CW   = 3;
    localparam int S    = 4;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic            a_rst = 1'b1, a_vld = 1'b0;
    logic [CW-1:0]   a_code = '0;
    logic            a_rdy, a_valid, a_busy, a_err;
    logic [NSTG-1:0] a_bk;
    logic [CW-1:0]   a_cur;

    logic            b_rst = 1'b1, b_vld = 1'b0;
    logic [CW-1:0]   b_code = '0;
    logic            b_rdy, b_valid, b_busy, b_err;
    logic [NSTG-1:0] b_bk;
    logic [CW-1:0]   b_cur;

    aibnd_dly_code_ctl #(.NSTG(NSTG), .CW(CW), .SETTLE(S)) dut_a (
        .ck(ck), .rst(a_rst), .req_vld(a_vld), .req_code(a_code), .req_rdy(a_rdy),
        .bk(a_bk), .code_valid(a_valid), .cur_code(a_cur), .busy(a_busy), .err(a_err)
    );

    aibnd_dly_code_ctl #(.NSTG(NSTG), .CW(CW), .SETTLE(0)) dut_b (
        .ck(ck), .rst(b_rst), .req_vld(b_vld), .req_code(b_code), .req_rdy(b_rdy),
        .bk(b_bk), .code_valid(b_valid), .cur_code(b_cur), .busy(b_busy), .err(b_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a transition is described by its acceptance cycle, start and target code;
    // every output at cycle n follows from the published step schedule.
    bit m_active = 0, m_valid = 0, m_err = 0;
    int m_T = 0, m_c0 = 0, m_t = 0, m_d = 0, m_cur = 0;
    bit last_acc = 0;
    int last_T = 0;
    logic [NSTG-1:0] prev_bk;
    bit prev_valid = 0, prev_rst = 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_done(input int n);
        return n >= m_T + 3 + m_d * (S + 1);
    endfunction

    function automatic int m_cur_at(input int n);
        int steps;
        if (!m_active) return m_cur;
        if (n < m_T + 3) return m_c0;
        steps = (n - m_T - 3) / (S + 1) + 1;
        if (steps > m_d) steps = m_d;
        return (m_t >= m_c0) ? m_c0 + steps : m_c0 - steps;
    endfunction

    function automatic bit m_busy(input int n);
        return m_active && !m_done(n);
    endfunction

    function automatic bit m_valid_at(input int n);
        return m_active ? m_done(n) : m_valid;
    endfunction

    task automatic step();
        int tgt, cnow;
        bit vnow, rdy_exp;
        #1;
        rdy_exp = !a_rst && !m_busy(cyc);
        chk("req_rdy", int'(a_rdy), int'(rdy_exp));
        last_acc = 0;
        if (a_rst) begin
            m_active = 0; m_cur = 0; m_valid = 0; m_err = 0;
        end else if (a_vld && rdy_exp) begin
            last_acc = 1;
            last_T   = cyc;
            tgt  = (int'(a_code) > NSTG) ? NSTG : int'(a_code);
            if (int'(a_code) > NSTG) m_err = 1;
            cnow = m_cur_at(cyc);
            vnow = m_valid_at(cyc);
            if (!(tgt == cnow && vnow)) begin
                m_active = 1; m_T = cyc; m_c0 = cnow; m_t = tgt;
                m_d = (tgt > cnow) ? tgt - cnow : cnow - tgt;
            end
        end
        prev_bk = a_bk; prev_valid = a_valid; prev_rst = a_rst;
        @(posedge ck);
        #1;
        cyc++;
        chk("cur_code", int'(a_cur), m_cur_at(cyc));
        chk("bk", int'(a_bk), (1 << m_cur_at(cyc)) - 1);
        chk("code_valid", int'(a_valid), int'(m_valid_at(cyc)));
        chk("busy", int'(a_busy), int'(m_busy(cyc)));
        chk("err", int'(a_err), int'(m_err));
        if (!prev_rst) begin
            chk("bk_onebit", int'($countones(a_bk ^ prev_bk) <= 1), 1);
            if (prev_valid) chk("bk_stable", int'(a_bk), int'(prev_bk));
        end
        if (m_active && m_done(cyc)) begin
            m_cur = m_t; m_valid = 1; m_active = 0;
        end
    endtask

    task automatic issue(input int code, output int t_acc, output bit ok);
        ok    = 0;
        t_acc = cyc;
        a_vld  = 1'b1;
        a_code = CW'(code);
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            if (last_acc) begin
                ok    = 1;
                t_acc = last_T;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_valid(input int t_acc, output int lat);
        bit found = 0;
        a_vld = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (a_valid === 1'b1 && a_busy === 1'b0) found = 1;
            else step();
        end
        if (!found) chk("valid_timeout", 0, 1);
        lat = cyc - t_acc;
    endtask

    typedef struct {
        int              code;
        logic [NSTG-1:0] bk;
        int              lat;
        bit              err;
    } vec_t;

    vec_t tbl[8];
    int   exp_b_cur[16];

    initial begin
        int t, lat;
        bit ok;

        tbl[0] = '{3, 6'b000111, 18, 1'b0};
        tbl[1] = '{1, 6'b000001, 13, 1'b0};
        tbl[2] = '{1, 6'b000001,  1, 1'b0};
        tbl[3] = '{0, 6'b000000,  8, 1'b0};
        tbl[4] = '{7, 6'b111111, 33, 1'b1};
        tbl[5] = '{6, 6'b111111,  1, 1'b1};
        tbl[6] = '{2, 6'b000011, 23, 1'b1};
        tbl[7] = '{6, 6'b111111, 23, 1'b1};

        step();
        step();
        a_rst = 1'b0;
        b_rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].code, t, ok);
            wait_valid(t, lat);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_bk", i), int'(a_bk), int'(tbl[i].bk));
            chk($sformatf("tbl%0d_err", i), int'(a_err), int'(tbl[i].err));
        end

        // Reset clears err; re-requesting code 0 while not yet valid still takes three cycles.
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
        chk("rst_err", int'(a_err), 0);
        issue(0, t, ok);
        wait_valid(t, lat);
        chk("reissue0_lat", lat, 3);

        // Reset during the settle wait of a 0->5 walk.
        issue(5, t, ok);
        a_vld = 1'b0;
        while (cyc < t + 10) step();
        chk("mid_bk", int'(a_bk), 3);
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
        chk("abort_bk", int'(a_bk), 0);
        chk("abort_cur", int'(a_cur), 0);
        chk("abort_valid", int'(a_valid), 0);
        chk("abort_busy", int'(a_busy), 0);
        step();
        chk("rdy_after_rst", int'(a_rdy), 1);

        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 14) == 0) begin
                a_vld = 1'b0;
                a_rst = 1'b1;
                step();
                a_rst = 1'b0;
            end
            issue(int'($urandom_range(0, 7)), t, ok);
            if ($urandom_range(0, 1) == 1) a_vld = 1'b0;
            for (int g = 0; g < int'($urandom_range(0, 40)); g++) step();
        end
        a_vld = 1'b0;
        step();

        // Zero-settle build: 0->6 on consecutive cycles while a second request is held pending.
        exp_b_cur = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 6, 6, 6, 5, 4, 3, 3};
        b_vld  = 1'b1;
        b_code = 3'd6;
        #1;
        chk("b_rdy0", int'(b_rdy), 1);
        @(posedge ck);
        #1;
        for (int k = 1; k <= 15; k++) begin
            b_code = 3'd3;
            b_vld  = (k <= 9);
            #1;
            chk($sformatf("b_cur%0d", k), int'(b_cur), exp_b_cur[k]);
            chk($sformatf("b_bk%0d", k), int'(b_bk), (1 << exp_b_cur[k]) - 1);
            chk($sformatf("b_valid%0d", k), int'(b_valid), int'(k == 9 || k >= 15));
            chk($sformatf("b_rdy%0d", k), int'(b_rdy), int'(k == 9 || k >= 15));
            chk($sformatf("b_busy%0d", k), int'(b_busy), int'(!(k == 9 || k >= 15)));
            @(posedge ck);
            #1;
        end
        chk("b_err", int'(b_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
